// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Produces one quotient bit per RUN cycle. result_o = {remainder, quotient}.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StPrep, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;      // raw dividend as latched
  logic [WIDTH-1:0]   dvs_q, dvs_d;      // raw divisor as latched
  logic               sgn_q, sgn_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   mag_q, mag_d;      // divisor magnitude used in RUN
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               last_bit;
  logic               dvs_zero;
  logic [WIDTH-1:0]   dvd_abs;
  logic [WIDTH-1:0]   dvs_abs;
  logic [WIDTH-1:0]   rem_sh;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   fin_rem;
  logic [WIDTH-1:0]   fin_quo;

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));
  assign dvs_zero = (dvs_q == '0);
  assign dvd_abs  = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
  assign dvs_abs  = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;

  // One restoring step: shift {rem, quo} left, then try subtracting the divisor.
  assign rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign trial  = {rem_q[WIDTH-1], rem_sh} - {1'b0, mag_q};

  // Sign fix-up of the magnitude result, modulo 2^WIDTH.
  assign fin_rem = neg_rem_q ? -rem_q : rem_q;
  assign fin_quo = neg_quo_q ? -quo_q : quo_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; annul cancels PREP/RUN but not a finished result.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_i && !annul_i) state_d = StPrep;
      StPrep: begin
        if (annul_i)       state_d = StIdle;
        else if (dvs_zero) state_d = StDone;
        else               state_d = StRun;
      end
      StRun: begin
        if (annul_i)       state_d = StIdle;
        else if (last_bit) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: the result is shown combinationally in DONE so ready_o and data coincide.
  always_comb begin
    ready_o  = (state_q == StDone);
    stall_o  = ((state_q == StIdle) && start_i && !annul_i) ||
               (state_q == StPrep) || (state_q == StRun);
    result_o = (state_q == StDone) ? {fin_rem, fin_quo} : result_q;
  end

  // Datapath next-state.
  always_comb begin
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    sgn_d     = sgn_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    mag_d     = mag_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && !annul_i) begin
          dvd_d = opdata1_i;
          dvs_d = opdata2_i;
          sgn_d = signed_i;
        end
      end
      StPrep: begin
        if (dvs_zero) begin
          // Divide by zero: all-ones quotient, raw dividend as remainder.
          quo_d     = '1;
          rem_d     = dvd_q;
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
        end else begin
          quo_d     = dvd_abs;
          rem_d     = '0;
          mag_d     = dvs_abs;
          cnt_d     = '0;
          neg_quo_d = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          neg_rem_d = sgn_q & dvd_q[WIDTH-1];
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
      end
      StDone: result_d = {fin_rem, fin_quo};
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      sgn_q     <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      mag_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      sgn_q     <= sgn_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      mag_q     <= mag_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected {rem, quo} and ready cycle,
// a monitor pops and compares whenever ready_o is seen.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  typedef struct {
    logic [63:0] res;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          checks;
  int          errors;
  logic [63:0] last_res;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .annul_i   (annul_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stall_o   (stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every ready_o pulse against the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ready_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 64'(ready_o), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("result", result_o, e.res);
          chk("ready_cycle", 64'(cyc), 64'(e.cyc));
          chk("stall_in_done", 64'(stall_o), 64'd0);
        end
      end
    end
  end

  task automatic drain(input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  // Issue one divide, count stalled cycles up to ready_o.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input int lat);
    exp_t e;
    int   nst;
    bit   got;
    opdata1_i = a;
    opdata2_i = b;
    signed_i  = s;
    start_i   = 1'b1;
    e.res = exp;
    e.cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    chk("stall_on_start", 64'(stall_o), 64'd1);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    nst = 0;
    got = 1'b0;
    for (int i = 0; i < lat + 10 && !got; i++) begin
      @(negedge clk);
      if (ready_o) got = 1'b1;
      else if (stall_o) nst++;
    end
    if (!got) begin
      chk("ready_timeout", 64'(got), 64'd1);
      sb.delete();
    end
    chk("stall_cycles", 64'(nst), 64'(lat - 1));
    last_res = exp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_res  = '0;
    rst       = 1'b1;
    start_i   = 1'b0;
    signed_i  = 1'b0;
    annul_i   = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result_o, 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors.
    run_div(32'd100,        32'd7,          1'b0, {32'd2, 32'd14},               34);
    run_div(32'hFFFFFFF9,   32'd2,          1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD},  34);
    run_div(32'd7,          32'hFFFFFFFE,   1'b1, {32'h1, 32'hFFFFFFFD},         34);
    run_div(32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, {32'hFFFFFFFE, 32'd14},        34);
    run_div(32'h1234,       32'd0,          1'b0, {32'h1234, 32'hFFFFFFFF},      2);
    run_div(32'h1234,       32'd0,          1'b1, {32'h1234, 32'hFFFFFFFF},      2);
    run_div(32'h80000000,   32'hFFFFFFFF,   1'b1, {32'h0, 32'h80000000},         34);
    run_div(32'h80000000,   32'hFFFFFFFF,   1'b0, {32'h80000000, 32'h0},         34);
    run_div(32'hFFFFFFFF,   32'd1,          1'b0, {32'h0, 32'hFFFFFFFF},         34);

    // annul_i in IDLE blocks the start.
    opdata1_i = 32'd5;
    opdata2_i = 32'd1;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    @(negedge clk);
    chk("annul_idle_stall", 64'(stall_o), 64'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    @(negedge clk);
    chk("annul_idle_not_started", 64'(stall_o), 64'd0);
    @(posedge clk);
    #1;

    // annul_i mid-RUN: back to IDLE, no ready, result held; then restart.
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    signed_i  = 1'b0;
    start_i   = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    @(negedge clk);
    chk("annul_run_stall", 64'(stall_o), 64'd0);
    chk("annul_run_ready", 64'(ready_o), 64'd0);
    chk("annul_run_result", result_o, last_res);
    @(posedge clk);
    #1;
    run_div(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 34);

    // start_i held through PREP and DONE of a divide-by-zero; re-accepted in IDLE.
    begin
      exp_t e;
      opdata1_i = 32'h1234;
      opdata2_i = 32'd0;
      signed_i  = 1'b0;
      start_i   = 1'b1;
      e.res = {32'h1234, 32'hFFFFFFFF};
      e.cyc = cyc + 2;
      sb.push_back(e);
      @(posedge clk);
      #1;
      opdata1_i = 32'd20;
      opdata2_i = 32'd3;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      e.res = {32'd2, 32'd6};
      e.cyc = cyc + 34;
      sb.push_back(e);
      @(posedge clk);
      #1;
      start_i = 1'b0;
      drain(60);
      last_res = {32'd2, 32'd6};
    end

    // Reset mid-RUN clears outputs at once.
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    start_i   = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrun_rst_result", result_o, 64'd0);
    chk("midrun_rst_ready", 64'(ready_o), 64'd0);
    chk("midrun_rst_stall", 64'(stall_o), 64'd0);
    @(posedge clk);
    #1;
    run_div(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 34);

    drain(50);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
